// File: rtl/spike_cls_pkg.sv
// rtl/spike_cls_pkg.sv - shared FSM states and constants for the spike vote classifier
package spike_cls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DRAIN,
    ST_SCAN,
    ST_DONE
  } state_e;

  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/spike_edge_counter.sv
// rtl/spike_edge_counter.sv - gated two-stage spike pipeline with rising-edge potential counter
// Counter saturates when SPIKE_CNT_SAT_EN is defined, otherwise wraps.
module spike_edge_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             gate_i,
  input  logic             en_t_i,
  input  logic             spike_i,
  output logic [CNT_W-1:0] count_o
);

  logic             g;
  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign g       = spike_i & en_t_i & gate_i;
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (s1_q && !s2_q) begin
`ifdef SPIKE_CNT_SAT_EN
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
`else
      cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= g;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spike_vote_classifier.sv
// rtl/spike_vote_classifier.sv - framed per-class spike counting with sequential arg-max vote
// Optional saturation of the class counters: SPIKE_CNT_SAT_EN.
module spike_vote_classifier
  import spike_cls_pkg::*;
#(
  parameter int  N_CLASS = 2,
  parameter int  CNT_W   = 3,
  localparam int CLS_W   = $clog2(N_CLASS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     window_end,
  input  logic                     en_t,
  input  logic [N_CLASS-1:0]       spike,
  input  logic                     ready,
  output logic [N_CLASS*CNT_W-1:0] potential,
  output logic                     busy,
  output logic                     valid,
  output logic [CLS_W-1:0]         class_id,
  output logic [CNT_W-1:0]         max_count
);

  localparam int IDX_W = $clog2(N_CLASS + 1);

  state_e           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic [CNT_W-1:0] max_q, max_d;

  logic [CNT_W-1:0] cnt_arr [N_CLASS];
  logic [CNT_W-1:0] cur_cnt;
  logic             clear;
  logic             gate;

  assign clear = (state_q == ST_IDLE) && start;
  assign gate  = (state_q == ST_COUNT);

  for (genvar i = 0; i < N_CLASS; i++) begin : g_cls
    spike_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .gate_i  (gate),
      .en_t_i  (en_t),
      .spike_i (spike[i]),
      .count_o (cnt_arr[i])
    );
    assign potential[i*CNT_W +: CNT_W] = cnt_arr[i];
  end

  // idx_q reaches N_CLASS only on the commit step, where cur_cnt is unused.
  assign cur_cnt = cnt_arr[idx_q[CLS_W-1:0]];

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    idx_d   = idx_q;
    cls_d   = cls_q;
    max_d   = max_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_COUNT;
      ST_COUNT: begin
        if (window_end) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDX_W'(N_CLASS)) begin
          state_d = ST_DONE;
        end else begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (idx_q == '0 || cur_cnt > max_q) begin
            cls_d = idx_q[CLS_W-1:0];
            max_d = cur_cnt;
          end
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: if (ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      idx_q   <= '0;
      cls_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      idx_q   <= idx_d;
      cls_q   <= cls_d;
      max_q   <= max_d;
    end
  end

  assign busy      = (state_q == ST_COUNT) || (state_q == ST_DRAIN) || (state_q == ST_SCAN);
  assign valid     = (state_q == ST_DONE);
  assign class_id  = cls_q;
  assign max_count = max_q;

endmodule

// File: tb/tb_spike_vote_classifier.sv
// tb/tb_spike_vote_classifier.sv - directed scoreboard bench for spike_vote_classifier
module tb_spike_vote_classifier;

  localparam int N = 4;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n, start, window_end, en_t, ready;
  logic [N-1:0]   spike;
  logic [N*W-1:0] potential;
  logic           busy, valid;
  logic [1:0]     class_id;
  logic [W-1:0]   max_count;

  typedef struct {
    int cls;
    int cnt;
  } res_t;

  res_t sb_q[$];
  int   model [N];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  spike_vote_classifier #(.N_CLASS(N), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .window_end (window_end),
    .en_t       (en_t),
    .spike      (spike),
    .ready      (ready),
    .potential  (potential),
    .busy       (busy),
    .valid      (valid),
    .class_id   (class_id),
    .max_count  (max_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] exp_potential();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(model[i]);
    return v;
  endfunction

  task automatic pulse(input logic [N-1:0] mask);
    spike = mask;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && en_t) begin
`ifdef SPIKE_CNT_SAT_EN
        if (model[i] < 7) model[i]++;
`else
        model[i] = (model[i] + 1) % 8;
`endif
      end
    end
    tick();
    spike = '0;
    tick();
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cleared"}, 32'(potential), 32'(exp_potential()));
  endtask

  task automatic push_expected();
    res_t r;
    r.cls = 0;
    for (int i = 1; i < N; i++) if (model[i] > model[r.cls]) r.cls = i;
    r.cnt = model[r.cls];
    sb_q.push_back(r);
  endtask

  task automatic finish_window(input string tag, input int hold);
    res_t r;
    int   k;
    check({tag, "_pot"}, 32'(potential), 32'(exp_potential()));
    push_expected();
    window_end = 1'b1;
    tick();
    window_end = 1'b0;
    k = 0;
    while (valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(3 + N));
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      check({tag, "_class"}, 32'(class_id), 32'(r.cls));
      check({tag, "_max"}, 32'(max_count), 32'(r.cnt));
      for (int c = 0; c < hold; c++) begin
        start = 1'b1;
        tick();
        check({tag, "_hold_valid"}, 32'(valid), 32'd1);
        check({tag, "_hold_class"}, 32'(class_id), 32'(r.cls));
        check({tag, "_hold_max"}, 32'(max_count), 32'(r.cnt));
      end
      start = 1'b0;
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; window_end = 1'b0; en_t = 1'b0; ready = 1'b0; spike = '0;
    for (int i = 0; i < N; i++) model[i] = 0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pot", 32'(potential), 32'd0);
    check("rst_class", 32'(class_id), 32'd0);
    check("rst_max", 32'(max_count), 32'd0);
    rst_n = 1'b1;
    en_t  = 1'b1;
    tick();

    // Basic count: 3 pulses on class 0, 5 on class 1.
    do_start("basic");
    for (int p = 0; p < 3; p++) pulse(4'b0011);
    for (int p = 0; p < 2; p++) pulse(4'b0010);
    finish_window("basic", 0);

    // Level held high counts once; pulses while en_t is low are ignored.
    do_start("level");
    spike = 4'b0001;
    model[0] = 1;
    for (int c = 0; c < 10; c++) tick();
    spike = '0;
    tick();
    en_t = 1'b0;
    for (int p = 0; p < 3; p++) pulse(4'b0010);
    en_t = 1'b1;
    finish_window("level", 0);

    // Tie {2,4,4,1} resolves to the lowest index; ready held low for 6 cycles.
    do_start("tie");
    pulse(4'b1111);
    pulse(4'b0111);
    pulse(4'b0110);
    pulse(4'b0110);
    finish_window("tie", 6);
    do_start("after_hs");
    finish_window("after_hs", 0);

    // Overflow: 9 pulses on a 3-bit counter.
    do_start("ovf");
    for (int p = 0; p < 9; p++) pulse(4'b0001);
`ifdef SPIKE_CNT_SAT_EN
    check("ovf_model", 32'(model[0]), 32'd7);
`else
    check("ovf_model", 32'(model[0]), 32'd1);
`endif
    finish_window("ovf", 0);

    // start and window_end together in IDLE: start wins, window stays open.
    start = 1'b1;
    window_end = 1'b1;
    tick();
    start = 1'b0;
    window_end = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 0;
    for (int c = 0; c < 10; c++) tick();
    check("both_busy", 32'(busy), 32'd1);
    check("both_valid", 32'(valid), 32'd0);
    pulse(4'b1000);
    finish_window("both", 0);

    // Reset in the middle of a window with class 0 at 5.
    do_start("midrst");
    for (int p = 0; p < 5; p++) pulse(4'b0001);
    check("midrst_pot5", 32'(potential), 32'(exp_potential()));
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < N; i++) model[i] = 0;
    check("midrst_pot", 32'(potential), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_class", 32'(class_id), 32'd0);
    check("midrst_max", 32'(max_count), 32'd0);
    rst_n = 1'b1;
    tick();
    do_start("post_rst");
    pulse(4'b0100);
    finish_window("post_rst", 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_vote_classifier.md
# spike_vote_classifier

Parametrised output-layer spike counter and winner-take-all classifier for the classification path. Each of N_CLASS output neurons has its spike train gated by en_t, edge-detected through a two-stage register pipeline, and counted in its own potential counter during a framed inference window. At window end the block drains the pipeline, scans all counters sequentially to find the arg-max class, and presents the result on a valid/ready handshake.

## Interface
Parameters:
- N_CLASS, 2: number of output neurons/classes (≥2).
- CNT_W, 3: potential counter width per class.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- start  in  1  pulse; opens a new window (clears counters). Honoured only in IDLE.
- window_end  in  1  pulse; closes the window. Honoured only in COUNT.
- en_t  in  1  spike gate; spikes counted only while high.
- spike  in  N_CLASS  per-class spike levels (bit i = class i).
- ready  in  1  downstream accepts result.
- potential  out  N_CLASS*CNT_W  counters, class i at [i*CNT_W +: CNT_W].
- busy  out  1  high in COUNT, DRAIN, SCAN.
- valid  out  1  result available (DONE state).
- class_id  out  CLS_W  winning class; CLS_W = $clog2(N_CLASS).
- max_count  out  CNT_W  winning counter value.

## Operation
- FSM states: IDLE, COUNT, DRAIN, SCAN, DONE.
- IDLE: start=1 → clear all counters and both pipeline stages, go COUNT.
- COUNT: per class g_i = spike[i] & en_t (combinational); s1_i <= g_i; s2_i <= s1_i; if s1_i & ~s2_i, counter_i increments. window_end=1 → DRAIN.
- DRAIN: g_i forced 0; 2 cycles so in-flight edges complete; then SCAN.
- SCAN: one class per cycle, index 0..N_CLASS-1; best replaced only on strictly greater count → ties resolve to lowest index. After index N_CLASS-1 → DONE.
- DONE: valid=1, class_id/max_count stable. valid & ready → IDLE (same edge). Counters keep final values until next start.
- start outside IDLE, window_end outside COUNT: ignored.
- start and window_end in same IDLE cycle: start wins, window_end ignored.
- Counter arithmetic per Configuration; unsigned, CNT_W bits.

## Timing
- Reset: state IDLE; potential, class_id, max_count, valid, busy, all s1/s2 = 0.
- Reset mid-operation (any state): same as above on the reset edge; pending result discarded.
- Spike latency: g_i rising sampled into s1 at edge k; counter shows +1 after edge k+1.
- A spike held high for M cycles counts once; re-counts only after ≥1 low cycle sampled.
- window_end at edge w: DRAIN for edges w+1, w+2; SCAN edges w+3 .. w+2+N_CLASS; valid high after edge w+3+N_CLASS.
- start → busy high after the accepting edge; valid → IDLE on the edge where ready=1.

## Configuration
- SPIKE_CNT_SAT_EN defined: counters saturate at 2^CNT_W−1; further edges ignored.
- Undefined: counters wrap modulo 2^CNT_W (7+1 → 0 at CNT_W=3).

## Structure
- Shared package spike_cls_pkg: FSM state enum, DRAIN_CYCLES=2 constant.
- One sub-module natural: spike_edge_counter (gate, 2-stage pipeline, edge detect, counter with SPIKE_CNT_SAT_EN), instantiated N_CLASS times by generate; top holds FSM and arg-max scan.

## Test plan
- Reset: assert rst_n=0 mid-COUNT with counters at 5 → next edge all outputs 0, state IDLE, busy=0.
- Basic count, N_CLASS=2: start, 3 pulses on spike[0], 5 on spike[1] with en_t=1, window_end → class_id=1, max_count=5, valid 5 cycles after window_end edge.
- Gating/level: spike[0] held high 10 cycles (counts 1); pulses with en_t=0 counted 0.
- Tie, N_CLASS=4: counts {2,4,4,1} → class_id=1, max_count=4.
- Overflow, CNT_W=3, 9 pulses: with SPIKE_CNT_SAT_EN → 7; without → 1.
- Handshake: hold ready=0 for 6 cycles → valid and outputs stable, start ignored; ready=1 → IDLE next edge, new start accepted.
